// File: rtl/md_pkg.sv
// ============================================================================
// Module : md_pkg
// Brief  : Shared encodings, default latencies and result type for the
//          multiply/divide sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // {hi, lo}
  typedef logic [63:0] md_res_t;

  localparam int C_MUL_CYCLES_DEF = 5;
  localparam int C_DIV_CYCLES_DEF = 10;
  localparam int C_CNT_W_DEF      = 4;

endpackage : md_pkg

`default_nettype wire

// File: rtl/md_arith.sv
// ============================================================================
// Module : md_arith
// Brief  : Combinational MIPS mult/multu/div/divu datapath returning {hi, lo}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_arith
  import md_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output md_res_t     o_res
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_sgn;
  logic        [31:0] w_mag_a;
  logic        [31:0] w_mag_b;
  logic        [31:0] w_div_b;
  logic        [31:0] w_q;
  logic        [31:0] w_r;
  logic        [31:0] w_q_fix;
  logic        [31:0] w_r_fix;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'b0, i_a} * {32'b0, i_b};

  // Signed divide works on magnitudes so INT_MIN / -1 stays well defined.
  assign w_sgn   = (i_op == MD_DIV);
  assign w_mag_a = (w_sgn && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign w_mag_b = (w_sgn && i_b[31]) ? (32'd0 - i_b) : i_b;
  assign w_div_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q     = w_mag_a / w_div_b;
  assign w_r     = w_mag_a % w_div_b;
  assign w_q_fix = (w_sgn && (i_a[31] ^ i_b[31])) ? (32'd0 - w_q) : w_q;
  assign w_r_fix = (w_sgn && i_a[31]) ? (32'd0 - w_r) : w_r;

  always_comb begin
    o_res = '0;
    case (i_op)
      MD_MULT:  o_res = w_prod_s;
      MD_MULTU: o_res = w_prod_u;
      MD_DIV, MD_DIVU: begin
        if (i_b == 32'd0) o_res = {i_a, 32'hFFFF_FFFF};
        else              o_res = {w_r_fix, w_q_fix};
      end
      default:  o_res = '0;
    endcase
  end

endmodule : md_arith

`default_nettype wire

// File: rtl/md_seq_ctrl.sv
// ============================================================================
// Module : md_seq_ctrl
// Brief  : E-stage multi-cycle mult/div sequencer owning HI/LO and MD stall.
//          Define MD_CANCEL_EN to add the cancel (flush) input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_seq_ctrl
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = C_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = C_DIV_CYCLES_DEF,
  parameter int CNT_W      = C_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  md_res_t          r_pend;
  md_res_t          w_res;
  logic             w_cancel;
  logic             w_is_arith;
  logic             w_is_div;

`ifdef MD_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  assign w_is_arith = (md_op <= 3'd3);
  assign w_is_div   = (md_op == MD_DIV) || (md_op == MD_DIVU);

  md_arith u_arith (
    .i_a   (a),
    .i_b   (b),
    .i_op  (md_op),
    .o_res (w_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_pend  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !w_cancel) begin
            if (w_is_arith) begin
              r_pend  <= w_res;
              r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end else if (md_op == MD_MTHI) begin
              r_hi <= a;
            end else if (md_op == MD_MTLO) begin
              r_lo <= a;
            end
          end
        end
        ST_RUN: begin
          // A start seen here is a pipeline error and is ignored.
          if (w_cancel) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_pend[63:32];
            r_lo    <= r_pend[31:0];
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign stall = md_use_D & (r_busy | (start & w_is_arith));

endmodule : md_seq_ctrl

`default_nettype wire

// File: tb/tb_md_seq_ctrl.sv
// ============================================================================
// Module : tb_md_seq_ctrl
// Brief  : Self-checking bench for md_seq_ctrl against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        md_use_D = 1'b0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
`ifdef MD_CANCEL_EN
    .cancel   (cancel),
`endif
    .start    (start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural HI/LO plus cycles left on the in-flight op.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_rem = 0;

  function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    res = '0;
    if (op == 3'd0) begin
      sq = sx * sy;
      res = sq;
    end else if (op == 3'd1) begin
      uq = ux * uy;
      res = uq;
    end else if (y == 32'd0) begin
      res = {x, 32'hFFFF_FFFF};
    end else if (op == 3'd2) begin
      sq = sx / sy;
      sr = sx % sy;
      res = {sr[31:0], sq[31:0]};
    end else begin
      uq = ux / uy;
      ur = ux % uy;
      res = {ur[31:0], uq[31:0]};
    end
    return res;
  endfunction

  function automatic logic cancel_active();
`ifdef MD_CANCEL_EN
    return cancel;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_pend = '0; m_rem = 0;
    end else if (m_rem > 0) begin
      if (cancel_active()) begin
        m_rem = 0;
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_hi = m_pend[63:32];
          m_lo = m_pend[31:0];
        end
      end
    end else if (start && !cancel_active()) begin
      if (md_op <= 3'd3) begin
        m_pend = ref_calc(md_op, a, b);
        m_rem  = (md_op >= 3'd2) ? 10 : 5;
      end else if (md_op == 3'd4) begin
        m_hi = a;
      end else if (md_op == 3'd5) begin
        m_lo = a;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic m_stall;
    m_stall = md_use_D && ((m_rem > 0) || (start && md_op <= 3'd3));
    chk("busy",  {31'b0, busy},  {31'b0, (m_rem > 0)});
    chk("stall", {31'b0, stall}, {31'b0, m_stall});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (start && m_rem > 0 && !reset) begin
      errors++;
      $display("FAIL start_in_run: start=%b while busy at %0t", start, $time);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; md_op = op; a = x; b = y;
    cyc();
    start = 1'b0;
  endtask

  // Counts busy cycles after an issue; a bounded wait reports a timeout.
  task automatic run_out(input string nm, input int exp_cycles);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      cyc();
    end
    chk(nm, n, exp_cycles);
  endtask

  initial begin
    repeat (3) cyc();
    reset = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    // mult -3 * 7 with a dependent MD op in D
    md_use_D = 1'b1;
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_stall", {31'b0, stall}, 32'h1);
    run_out("mult_cycles", 5);
    md_use_D = 1'b0;
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_out("div_cycles", 10);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    // back-to-back: issue on the first idle cycle after commit
    issue(3'd3, 32'd7, 32'd2);
    run_out("divu_cycles", 10);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    issue(3'd3, 32'h1234, 32'd0);
    run_out("div0_cycles", 10);
    chk("div0_hi", hi, 32'h1234);
    chk("div0_lo", lo, 32'hFFFF_FFFF);

    md_use_D = 1'b1;
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    issue(3'd5, 32'h1, 32'd0);
    chk("mt_busy", {31'b0, busy}, 32'h0);
    chk("mt_stall", {31'b0, stall}, 32'h0);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mtlo_lo", lo, 32'h1);
    md_use_D = 1'b0;

    // reset in the third RUN cycle of a multu
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    cyc(); cyc();
    reset = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    cyc();
    reset = 1'b0;
    repeat (8) cyc();
    chk("rst_nocommit_hi", hi, 32'h0);
    chk("rst_nocommit_lo", lo, 32'h0);

    // cancel in the second RUN cycle of mult
    issue(3'd4, 32'h55, 32'd0);
    issue(3'd5, 32'h66, 32'd0);
    issue(3'd0, 32'd3, 32'd5);
    cyc();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    repeat (6) cyc();
`ifdef MD_CANCEL_EN
    chk("cancel_hi", hi, 32'h55);
    chk("cancel_lo", lo, 32'h66);
`else
    chk("cancel_hi", hi, 32'h0);
    chk("cancel_lo", lo, 32'd15);
`endif

    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      md_use_D = $urandom_range(0, 1) == 1;
      md_op    = 3'($urandom_range(0, 7));
      a        = $urandom();
      b        = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      start    = (m_rem == 0) && ($urandom_range(0, 2) == 0);
`ifdef MD_CANCEL_EN
      cancel   = ($urandom_range(0, 19) == 0);
`endif
      cyc();
    end
    reset = 1'b0; start = 1'b0; cancel = 1'b0;
    repeat (12) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_md_seq_ctrl

`default_nettype wire
